// File: rtl/dcache_pkg.sv
// dcache_pkg: FSM state encoding, default geometry and address field helpers
// for the direct-mapped write-back data cache.
package dcache_pkg;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_OFFSET_W = 2;
    localparam int DEF_INDEX_W  = 3;
    localparam int DEF_CNT_W    = 16;
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2
    } state_t;
    function automatic int tag_lsb(input int offset_w, input int index_w);
        return offset_w + index_w;
    endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: CPU load/store port and block-wide memory port of the cache.
// slave is the cache's view, master is the CPU/memory environment's view.
interface dcache_if import dcache_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int INDEX_W  = DEF_INDEX_W
);
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCK_W = DATA_W << OFFSET_W;
    logic                       READ;
    logic                       WRITE;
    logic [ADDR_W-1:0]          ADDRESS;
    logic [DATA_W-1:0]          WRITEDATA;
    logic [DATA_W-1:0]          READDATA;
    logic                       BUSYWAIT;
    logic                       MEM_READ;
    logic                       MEM_WRITE;
    logic [TAG_W+INDEX_W-1:0]   MEM_ADDRESS;
    logic [BLOCK_W-1:0]         MEM_WRITEDATA;
    logic [BLOCK_W-1:0]         MEM_READDATA;
    logic                       MEM_BUSYWAIT;
    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );
    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );
endinterface

// File: rtl/dcache_stats.sv
// dcache_stats: saturating hit/miss/write-back counters; the hit that
// re-checks a request right after its refill is not counted.
module dcache_stats #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_hit,
    input  logic             i_miss,
    input  logic             i_wb,
    input  logic             i_fill,
    output logic [CNT_W-1:0] o_hit_cnt,
    output logic [CNT_W-1:0] o_miss_cnt,
    output logic [CNT_W-1:0] o_wb_cnt
);
    logic             r_refilled;
    logic [CNT_W-1:0] r_hit, r_miss, r_wb;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_refilled <= 1'b0;
            r_hit      <= '0;
            r_miss     <= '0;
            r_wb       <= '0;
        end else begin
            r_refilled <= i_fill;
            if (i_hit && !r_refilled && !(&r_hit)) r_hit <= r_hit + 1'b1;
            if (i_miss && !(&r_miss)) r_miss <= r_miss + 1'b1;
            if (i_wb && !(&r_wb)) r_wb <= r_wb + 1'b1;
        end
    end
    assign o_hit_cnt  = r_hit;
    assign o_miss_cnt = r_miss;
    assign o_wb_cnt   = r_wb;
endmodule

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-back, write-allocate data cache with a
// three-state miss FSM (IDLE / WRITEBACK / FETCH) and statistics counters.
module dcache_dm import dcache_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    dcache_if.slave          bus,
    output logic [CNT_W-1:0] HIT_CNT,
    output logic [CNT_W-1:0] MISS_CNT,
    output logic [CNT_W-1:0] WB_CNT
);
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCK_W = DATA_W << OFFSET_W;
    localparam int SETS    = 1 << INDEX_W;
    localparam int TAG_LSB = tag_lsb(OFFSET_W, INDEX_W);
    logic [BLOCK_W-1:0]  r_data [SETS];
    logic [TAG_W-1:0]    r_tag  [SETS];
    logic [SETS-1:0]     r_valid, r_dirty;
    state_t              r_state, w_next;
    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_idx;
    logic [OFFSET_W-1:0] w_off;
    logic w_req, w_hit, w_idle, w_miss, w_wb_done, w_fill, w_store, w_rd_hit;
    assign w_tag    = bus.ADDRESS[TAG_LSB +: TAG_W];
    assign w_idx    = bus.ADDRESS[OFFSET_W +: INDEX_W];
    assign w_off    = bus.ADDRESS[OFFSET_W-1:0];
    assign w_idle   = r_state == S_IDLE;
    assign w_req    = bus.READ | bus.WRITE;
    assign w_hit    = r_valid[w_idx] && r_tag[w_idx] == w_tag;
    assign w_store  = w_idle && bus.WRITE && w_hit;
    assign w_rd_hit = w_idle && bus.READ && !bus.WRITE && w_hit;
    always_comb begin
        w_miss    = w_idle && w_req && !w_hit;
        w_wb_done = r_state == S_WRITEBACK && !bus.MEM_BUSYWAIT;
        w_fill    = r_state == S_FETCH && !bus.MEM_BUSYWAIT;
        w_next    = w_miss ? ((r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_FETCH) :
                    w_wb_done ? S_FETCH : w_fill ? S_IDLE : r_state;
    end
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_next;
            if (w_fill) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end else if (w_store) r_dirty[w_idx] <= 1'b1;
        end
    end
    // data and tags carry no reset; valid gates their use
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_data[w_idx] <= bus.MEM_READDATA;
            r_tag[w_idx]  <= w_tag;
        end else if (w_store) r_data[w_idx][w_off*DATA_W +: DATA_W] <= bus.WRITEDATA;
    end
    assign bus.BUSYWAIT      = RESET && (w_miss || !w_idle);
    assign bus.READDATA      = (RESET && w_rd_hit) ? r_data[w_idx][w_off*DATA_W +: DATA_W] : '0;
    assign bus.MEM_READ      = r_state == S_FETCH;
    assign bus.MEM_WRITE     = r_state == S_WRITEBACK;
    assign bus.MEM_ADDRESS   = {(r_state == S_WRITEBACK) ? r_tag[w_idx] : w_tag, w_idx};
    assign bus.MEM_WRITEDATA = r_data[w_idx];
    dcache_stats #(.CNT_W(CNT_W)) u_stats (
        .CLK        (CLK),
        .RESET      (RESET),
        .i_hit      (w_idle && w_req && w_hit),
        .i_miss     (w_miss),
        .i_wb       (w_wb_done),
        .i_fill     (w_fill),
        .o_hit_cnt  (HIT_CNT),
        .o_miss_cnt (MISS_CNT),
        .o_wb_cnt   (WB_CNT)
    );
endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: randomized scoreboard bench; the reference is a flat byte
// memory plus a per-set residency table, checked against a block memory model.
module tb_dcache_dm;
    localparam int CW  = 6;
    localparam int MAX = (1 << CW) - 1;
    logic CLK = 0;
    logic RESET = 0;
    always #5 CLK = ~CLK;
    dcache_if #(.DATA_W(8), .ADDR_W(8), .OFFSET_W(2), .INDEX_W(3)) bus ();
    logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;
    dcache_dm #(.DATA_W(8), .ADDR_W(8), .OFFSET_W(2), .INDEX_W(3), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus),
        .HIT_CNT(hit_cnt), .MISS_CNT(miss_cnt), .WB_CNT(wb_cnt)
    );
    typedef struct {
        bit         miss;
        logic [7:0] data;
        int         hit, mis, wb;
    } exp_t;
    logic [31:0] mem [64];
    logic [7:0]  ref_mem [256];
    bit          m_valid [8];
    bit          m_dirty [8];
    int          m_tag [8];
    int          m_hit, m_miss, m_wb;
    exp_t        q[$];
    exp_t        pend;
    bit          pend_v;
    int          stall;
    int          errors, checks;
    int          cur_blk, exp_wb_blk;
    bit          hold, active;
    int          cnt;
    logic [5:0]  t_addr;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, want, $time);
        end
    endtask

    function automatic int sat(input int x);
        return x > MAX ? MAX : x;
    endfunction

    function automatic logic [31:0] ref_blk(input int b);
        return {ref_mem[b*4+3], ref_mem[b*4+2], ref_mem[b*4+1], ref_mem[b*4]};
    endfunction

    // a reset throws away every cached block, so the CPU view reverts to memory
    task automatic reset_model();
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 0;
            m_dirty[s] = 0;
            m_tag[s]   = 0;
        end
        m_hit = 0; m_miss = 0; m_wb = 0;
        for (int b = 0; b < 64; b++)
            for (int w = 0; w < 4; w++) ref_mem[b*4+w] = mem[b][w*8 +: 8];
    endtask

    task automatic do_req(input bit wr, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        int ai, s, t, n;
        ai = int'(a);
        s  = (ai >> 2) & 7;
        t  = ai >> 5;
        e.miss = !(m_valid[s] && m_tag[s] == t);
        cur_blk    = ai >> 2;
        exp_wb_blk = m_tag[s] * 8 + s;
        if (e.miss) begin
            m_miss++;
            if (m_valid[s] && m_dirty[s]) m_wb++;
            m_valid[s] = 1; m_tag[s] = t; m_dirty[s] = 0;
        end else m_hit++;
        if (wr) begin
            m_dirty[s] = 1;
            ref_mem[ai] = d;
        end
        e.data = wr ? 8'h00 : ref_mem[ai];
        e.hit = sat(m_hit); e.mis = sat(m_miss); e.wb = sat(m_wb);
        q.push_back(e);
        bus.WRITE     = wr;
        bus.READ      = wr ? 1'($urandom % 2) : 1'b1;
        bus.ADDRESS   = a;
        bus.WRITEDATA = d;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus.BUSYWAIT && n < 300);
        chk("req_done", 32'(bus.BUSYWAIT), 32'd0);
        @(posedge CLK);
        #1;
        bus.READ  = 0;
        bus.WRITE = 0;
    endtask

    always @(negedge CLK) begin
        if (pend_v && RESET) begin
            chk("hit_cnt", 32'(hit_cnt), 32'(pend.hit));
            chk("miss_cnt", 32'(miss_cnt), 32'(pend.mis));
            chk("wb_cnt", 32'(wb_cnt), 32'(pend.wb));
            pend_v = 0;
        end
        if (RESET && (bus.READ || bus.WRITE)) begin
            if (bus.BUSYWAIT) stall++;
            else if (q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
            else begin
                pend = q.pop_front();
                chk("readdata", 32'(bus.READDATA), 32'(pend.data));
                chk("stalled", 32'(stall != 0), 32'(pend.miss));
                stall  = 0;
                pend_v = 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (!(bus.MEM_READ || bus.MEM_WRITE)) begin
            active = 0;
            bus.MEM_BUSYWAIT = 1;
        end else begin
            if (!active) begin
                active = 1;
                cnt    = int'($urandom_range(0, 4));
                t_addr = bus.MEM_ADDRESS;
                if (bus.MEM_READ) chk("fetch_addr", 32'(bus.MEM_ADDRESS), 32'(cur_blk));
                else begin
                    chk("wb_addr", 32'(bus.MEM_ADDRESS), 32'(exp_wb_blk));
                    chk("wb_data", bus.MEM_WRITEDATA, ref_blk(exp_wb_blk));
                end
            end else chk("mem_addr_stable", 32'(bus.MEM_ADDRESS), 32'(t_addr));
            if (hold || cnt > 0) begin
                if (!hold) cnt--;
                bus.MEM_BUSYWAIT = 1;
            end else begin
                bus.MEM_BUSYWAIT = 0;
                active = 0;
                if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
                else bus.MEM_READDATA = mem[bus.MEM_ADDRESS];
            end
        end
    end

    initial begin
        int n;
        bit wr;
        logic [7:0] a;
        errors = 0; checks = 0; hold = 0; pend_v = 0; stall = 0;
        bus.READ = 0; bus.WRITE = 0; bus.ADDRESS = 0; bus.WRITEDATA = 0;
        bus.MEM_READDATA = 0;
        for (int b = 0; b < 64; b++) mem[b] = $urandom;
        mem[0] = 32'h44332211;
        reset_model();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busywait", 32'(bus.BUSYWAIT), 32'd0);
        chk("rst_mem_read", 32'(bus.MEM_READ), 32'd0);
        chk("rst_mem_write", 32'(bus.MEM_WRITE), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        RESET = 1;
        @(posedge CLK);
        #1;
        do_req(0, 8'h00, 8'h00);
        do_req(0, 8'h03, 8'h00);
        do_req(1, 8'h01, 8'hAB);
        do_req(0, 8'h01, 8'h00);
        do_req(0, 8'h20, 8'h00);
        do_req(1, 8'h45, 8'h5C);
        do_req(0, 8'h45, 8'h00);
        do_req(0, 8'h00, 8'h00);
        // abort a refill with reset while memory is still busy
        hold = 1;
        cur_blk = 8'h88 >> 2;
        bus.ADDRESS = 8'h88;
        bus.READ = 1;
        n = 0;
        while (!bus.MEM_READ && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("fetch_started", 32'(bus.MEM_READ), 32'd1);
        #2 RESET = 0;
        #1;
        chk("abort_mem_read", 32'(bus.MEM_READ), 32'd0);
        chk("abort_busywait", 32'(bus.BUSYWAIT), 32'd0);
        chk("abort_readdata", 32'(bus.READDATA), 32'd0);
        chk("abort_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("abort_hit_cnt", 32'(hit_cnt), 32'd0);
        q.delete();
        stall = 0;
        pend_v = 0;
        reset_model();
        hold = 0;
        bus.READ = 0;
        @(posedge CLK);
        #1 RESET = 1;
        do_req(0, 8'h88, 8'h00);
        do_req(0, 8'h45, 8'h00);
        repeat (400) begin
            wr = ($urandom % 3) == 0;
            a  = {3'($urandom_range(0, 3)), 5'($urandom)};
            do_req(wr, a, 8'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
        end
        repeat (3) @(posedge CLK);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
